// File: rtl/pinky_pkg.sv
// Shared definitions for the pinky pipeline: datapath widths, FPU opcodes,
// scheduler state encoding and the FPU instruction width.
package pinky_pkg;

   localparam int WORD        = 16;
   localparam int REG         = 4;
   localparam int OPC_W       = 5;
   localparam int FPU_INSTR_W = 6;

   localparam logic [OPC_W-1:0] OPitof = 5'b10010;
   localparam logic [OPC_W-1:0] OPftoi = 5'b10011;
   localparam logic [OPC_W-1:0] OPrecf = 5'b10100;
   localparam logic [OPC_W-1:0] OPmulf = 5'b10101;
   localparam logic [OPC_W-1:0] OPsubf = 5'b10110;
   localparam logic [OPC_W-1:0] OPaddf = 5'b10111;

   typedef enum logic [1:0] {
      SCH_IDLE = 2'd0,
      SCH_RUN  = 2'd1,
      SCH_WB   = 2'd2
   } sch_state_e;

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational opcode classifier: flags FPU opcodes and forms the FPU instr word.
// Shared with the stage-1 interlock logic.
module fpu_op_decode
   import pinky_pkg::*;
(
   input  logic [OPC_W-1:0]       opcode,
   output logic                   is_fpu,
   output logic [FPU_INSTR_W-1:0] fpu_instr
);

   // Classify the opcode; the FPU instr is the opcode zero-extended by one bit.
   always_comb begin
      is_fpu    = 1'b0;
      fpu_instr = {1'b0, opcode};
      case (opcode)
         OPitof, OPftoi, OPrecf, OPmulf, OPsubf, OPaddf: is_fpu = 1'b1;
         default:                                        is_fpu = 1'b0;
      endcase
   end

endmodule

// File: rtl/fpu_sched.sv
// Issue/sequencing controller between the execute stage and the multi-cycle FPU:
// one op in flight, qualified done, watchdog, and a valid/ready writeback port.
module fpu_sched
   import pinky_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [OPC_W-1:0]       req_opcode,
   input  logic [WORD-1:0]        req_op1,
   input  logic [WORD-1:0]        req_op2,
   input  logic [REG-1:0]         req_dest,
   input  logic                   flush,
   output logic                   fpu_en,
   output logic [FPU_INSTR_W-1:0] fpu_instr,
   output logic [WORD-1:0]        fpu_op1,
   output logic [WORD-1:0]        fpu_op2,
   input  logic [WORD-1:0]        fpu_result,
   input  logic                   fpu_done,
   output logic                   wb_valid,
   input  logic                   wb_ready,
   output logic [REG-1:0]         wb_dest,
   output logic [WORD-1:0]        wb_data,
   output logic                   wb_err,
   output logic                   busy,
   output logic [REG-1:0]         busy_dest,
   output logic                   stall
);

   sch_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [FPU_INSTR_W-1:0] instr_q, instr_d;
   logic [WORD-1:0]        op1_q, op1_d;
   logic [WORD-1:0]        op2_q, op2_d;
   logic [REG-1:0]         dest_q, dest_d;
   logic [WORD-1:0]        wb_data_q, wb_data_d;
   logic                   wb_err_q, wb_err_d;
   logic                   fpu_en_q, fpu_en_d;
   logic                   wb_valid_q, wb_valid_d;
   logic [REG-1:0]         busy_dest_q, busy_dest_d;

   logic                   dec_is_fpu;
   logic [FPU_INSTR_W-1:0] dec_instr;

   fpu_op_decode u_dec (
      .opcode    (req_opcode),
      .is_fpu    (dec_is_fpu),
      .fpu_instr (dec_instr)
   );

   assign req_ready = (state_q == SCH_IDLE) && !flush;
   assign busy      = (state_q != SCH_IDLE);
   assign stall     = busy || (req_valid && !req_ready);

   assign fpu_en    = fpu_en_q;
   assign fpu_instr = instr_q;
   assign fpu_op1   = op1_q;
   assign fpu_op2   = op2_q;
   assign wb_valid  = wb_valid_q;
   assign wb_dest   = dest_q;
   assign wb_data   = wb_data_q;
   assign wb_err    = wb_err_q;
   assign busy_dest = busy_dest_q;

   // Next-state and datapath latch logic for the IDLE/RUN/WB sequencer.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      instr_d   = instr_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      dest_d    = dest_q;
      wb_data_d = wb_data_q;
      wb_err_d  = wb_err_q;
      case (state_q)
         SCH_IDLE: begin
            if (req_valid && !flush) begin
               instr_d = dec_instr;
               op1_d   = req_op1;
               op2_d   = req_op2;
               dest_d  = req_dest;
               cnt_d   = {CNT_W{1'b0}};
               if (dec_is_fpu) begin
                  state_d = SCH_RUN;
               end else begin
                  state_d   = SCH_WB;
                  wb_err_d  = 1'b1;
                  wb_data_d = {WORD{1'b0}};
               end
            end else begin
               state_d = SCH_IDLE;
            end
         end
         SCH_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            // cnt_q == 0 marks the first RUN cycle, where done may be left over from the previous op.
            if (flush) begin
               state_d = SCH_IDLE;
            end else if (fpu_done && (cnt_q != {CNT_W{1'b0}})) begin
               state_d   = SCH_WB;
               wb_data_d = fpu_result;
               wb_err_d  = 1'b0;
            end else if (cnt_d == CNT_W'(TIMEOUT)) begin
               state_d   = SCH_WB;
               wb_data_d = {WORD{1'b0}};
               wb_err_d  = 1'b1;
            end else begin
               state_d = SCH_RUN;
            end
         end
         SCH_WB: begin
            if (flush || wb_ready) begin
               state_d = SCH_IDLE;
            end else begin
               state_d = SCH_WB;
            end
         end
         default: begin
            state_d = SCH_IDLE;
         end
      endcase
      fpu_en_d    = (state_d == SCH_RUN);
      wb_valid_d  = (state_d == SCH_WB);
      busy_dest_d = (state_d != SCH_IDLE) ? dest_d : {REG{1'b0}};
   end

   // State and output registers; reset abandons any op in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SCH_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         instr_q     <= {FPU_INSTR_W{1'b0}};
         op1_q       <= {WORD{1'b0}};
         op2_q       <= {WORD{1'b0}};
         dest_q      <= {REG{1'b0}};
         wb_data_q   <= {WORD{1'b0}};
         wb_err_q    <= 1'b0;
         fpu_en_q    <= 1'b0;
         wb_valid_q  <= 1'b0;
         busy_dest_q <= {REG{1'b0}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         instr_q     <= instr_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         dest_q      <= dest_d;
         wb_data_q   <= wb_data_d;
         wb_err_q    <= wb_err_d;
         fpu_en_q    <= fpu_en_d;
         wb_valid_q  <= wb_valid_d;
         busy_dest_q <= busy_dest_d;
      end
   end

endmodule

// File: tb/tb_fpu_sched.sv
// Scoreboard bench for fpu_sched: directed cases plus random ops against a
// cycle-level FPU model and an op-level reference of the scheduler's contract.
module tb_fpu_sched;

   localparam int TO = 15;
   localparam logic [4:0] TB_ITOF = 5'b10010;

   typedef struct {
      logic [3:0]  dest;
      logic [15:0] data;
      logic        err;
   } exp_t;

   logic        clk, reset;
   logic        req_valid, req_ready, flush;
   logic [4:0]  req_opcode;
   logic [15:0] req_op1, req_op2;
   logic [3:0]  req_dest;
   logic        fpu_en, fpu_done;
   logic [5:0]  fpu_instr;
   logic [15:0] fpu_op1, fpu_op2, fpu_result;
   logic        wb_valid, wb_ready, wb_err;
   logic [3:0]  wb_dest, busy_dest;
   logic [15:0] wb_data;
   logic        busy, stall;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t exp_q[$];

   // FPU model controls, set by the stimulus before each request
   int          m_lat   = 0;
   bit          m_stale = 1'b0;
   logic [15:0] m_res   = 16'h0;
   logic [5:0]  m_instr = 6'h0;
   logic [15:0] m_op1   = 16'h0;
   logic [15:0] m_op2   = 16'h0;

   fpu_sched #(.TIMEOUT(TO), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_op1(req_op1), .req_op2(req_op2), .req_dest(req_dest), .flush(flush),
      .fpu_en(fpu_en), .fpu_instr(fpu_instr), .fpu_op1(fpu_op1), .fpu_op2(fpu_op2),
      .fpu_result(fpu_result), .fpu_done(fpu_done),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
      .wb_err(wb_err), .busy(busy), .busy_dest(busy_dest), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit ref_is_fpu(input logic [4:0] opc);
      return (int'(opc) >= 18) && (int'(opc) <= 23);
   endfunction

   // int16 -> bfloat16, mantissa truncated
   function automatic logic [15:0] itof_ref(input logic [15:0] v);
      int s, a, p, m;
      if (v == 16'h0) return 16'h0;
      s = int'(v[15]);
      a = (s != 0) ? (65536 - int'(v)) : int'(v);
      p = 0;
      while ((a >> (p + 1)) != 0) p++;
      m = (p >= 7) ? ((a >> (p - 7)) & 127) : ((a << (7 - p)) & 127);
      return {s[0], 8'(127 + p), 7'(m)};
   endfunction

   // FPU model: done on the m_lat-th enabled cycle, optional stale done outside RUN
   initial begin
      int run_idx;
      run_idx = 0;
      fpu_done = 1'b0;
      fpu_result = 16'h0;
      forever begin
         @(negedge clk);
         #1;
         if (fpu_en) begin
            run_idx++;
            check("fpu_instr", 32'(fpu_instr), 32'(m_instr));
            check("fpu_op1", 32'(fpu_op1), 32'(m_op1));
            check("fpu_op2", 32'(fpu_op2), 32'(m_op2));
         end else begin
            run_idx = 0;
         end
         if (fpu_en && run_idx == m_lat) begin
            fpu_done = 1'b1;
            fpu_result = m_res;
         end else if (m_stale && (!fpu_en || run_idx == 1)) begin
            fpu_done = 1'b1;
            fpu_result = 16'hDEAD;
         end else begin
            fpu_done = 1'b0;
            fpu_result = 16'h0;
         end
      end
   end

   // Monitor: every writeback handshake is matched against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
               check("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("wb_dest", 32'(wb_dest), 32'(e.dest));
               check("wb_data", 32'(wb_data), 32'(e.data));
               check("wb_err", 32'(wb_err), 32'(e.err));
            end
         end
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_busy_dest"}, 32'(busy_dest), 32'd0);
      check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
      check({tag, "_fpu_en"}, 32'(fpu_en), 32'd0);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_stall"}, 32'(stall), 32'd0);
   endtask

   // One operation; abort_at>0 flushes (or resets) in that cycle after acceptance
   task automatic do_op(input logic [4:0] opc, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] d, input int lat, input bit stale,
                        input int ready_dly, input int abort_at, input bit abort_rst);
      bit   fpu, accepted, finished;
      int   r;
      exp_t e;
      logic [15:0] res;
      fpu = ref_is_fpu(opc);
      res = (opc == TB_ITOF) ? itof_ref(b) : 16'($urandom);
      e.dest = d;
      if (fpu && lat >= 2 && lat <= TO) begin
         r = lat; e.err = 1'b0; e.data = res;
      end else begin
         r = fpu ? TO : 0; e.err = 1'b1; e.data = 16'h0;
      end
      m_lat = lat; m_res = res; m_stale = stale;
      m_instr = {1'b0, opc}; m_op1 = a; m_op2 = b;
      @(negedge clk);
      req_valid = 1'b1; req_opcode = opc; req_op1 = a; req_op2 = b; req_dest = d;
      flush = 1'b0; wb_ready = 1'b0;
      accepted = 1'b0;
      for (int w = 0; w < 20 && !accepted; w++) begin
         if (w > 0) @(negedge clk);
         #3;
         if (req_ready) accepted = 1'b1;
      end
      check("req_accept", 32'(accepted), 32'd1);
      if (!accepted) begin
         req_valid = 1'b0;
         return;
      end
      exp_q.push_back(e);
      finished = 1'b0;
      for (int c = 1; c <= 200 && !finished; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (abort_at == c) begin
            wb_ready = 1'b0;
            void'(exp_q.pop_back());
            finished = 1'b1;
            if (abort_rst) begin
               #2 reset = 1'b0;
               #1;
               check("rst_wb_valid", 32'(wb_valid), 32'd0);
               check("rst_wb_data", 32'(wb_data), 32'd0);
               check("rst_wb_err", 32'(wb_err), 32'd0);
               check("rst_wb_dest", 32'(wb_dest), 32'd0);
               check("rst_fpu_instr", 32'(fpu_instr), 32'd0);
               check_idle("rst");
               #1 reset = 1'b1;
            end else begin
               flush = 1'b1;
            end
         end else begin
            wb_ready = (c >= r + 1 + ready_dly);
            #3;
            check("run_stall", 32'(stall), 32'd1);
            check("run_busy_dest", 32'(busy_dest), 32'(d));
            check("run_fpu_en", 32'(fpu_en), 32'(c <= r));
            check("run_wb_valid", 32'(wb_valid), 32'(c > r));
            if (c > r) check("wb_hold_data", 32'(wb_data), 32'(e.data));
            if (wb_ready) finished = 1'b1;
         end
      end
      check("op_finished", 32'(finished), 32'd1);
      @(negedge clk);
      flush = 1'b0; wb_ready = 1'b0;
      #3;
      check_idle("post");
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_opcode = 5'h0; req_op1 = 16'h0;
      req_op2 = 16'h0; req_dest = 4'h0; flush = 1'b0; wb_ready = 1'b0;
      #13;
      check("init_wb_data", 32'(wb_data), 32'd0);
      check("init_wb_err", 32'(wb_err), 32'd0);
      check_idle("init");
      @(negedge clk);
      reset = 1'b1;

      do_op(TB_ITOF, 16'h1234, 16'h0005, 4'd3, 3, 1'b0, 0, 0, 1'b0);
      do_op(TB_ITOF, 16'h0000, 16'hFFFF, 4'd5, 5, 1'b0, 2, 0, 1'b0);
      do_op(TB_ITOF, 16'h0000, 16'h0000, 4'd6, 2, 1'b1, 0, 0, 1'b0);
      do_op(5'b00000, 16'h1111, 16'h2222, 4'd7, 3, 1'b0, 1, 0, 1'b0);
      do_op(5'b10101, 16'h3C00, 16'h4000, 4'd8, 0, 1'b0, 0, 0, 1'b0);
      do_op(5'b10111, 16'h3F80, 16'h3F80, 4'd9, 4, 1'b0, 0, 4, 1'b0);
      do_op(5'b10110, 16'h0001, 16'h0002, 4'd15, 15, 1'b0, 0, 0, 1'b0);
      do_op(5'b10100, 16'h0003, 16'h0004, 4'd2, 16, 1'b0, 0, 0, 1'b0);
      do_op(5'b10011, 16'h0005, 16'h0006, 4'd1, 1, 1'b0, 0, 0, 1'b0);

      // flush in IDLE blocks acceptance
      @(negedge clk);
      req_valid = 1'b1; req_opcode = TB_ITOF; flush = 1'b1;
      #3;
      check("idle_flush_ready", 32'(req_ready), 32'd0);
      check("idle_flush_stall", 32'(stall), 32'd1);
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      #3;
      check_idle("idle_flush");

      do_op(TB_ITOF, 16'h0000, 16'h0007, 4'd4, 3, 1'b0, 100, 8, 1'b1);

      for (int i = 0; i < 40; i++) begin
         logic [4:0] opc;
         int lat, ab, pick;
         opc = ($urandom_range(0, 9) < 7) ? 5'(18 + $urandom_range(0, 5)) : 5'($urandom_range(0, 31));
         pick = $urandom_range(0, 9);
         lat = (pick == 0) ? 0 : (pick == 1) ? int'($urandom_range(15, 16)) : int'($urandom_range(1, 8));
         ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, (lat >= 2 && lat <= TO) ? lat + 2 : TO + 2)) : 0;
         do_op(opc, 16'($urandom), 16'($urandom), 4'($urandom), lat,
               ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), ab, 1'b0);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/fpu_sched.md
Name: fpu_sched

Overview:
- Issue/sequencing controller between the pipeline execute stage and the multi-cycle `fpu`.
- Accepts one FPU request at a time over a valid/ready handshake and drives the FPU `en`/`instr`/operand inputs.
- Qualifies `done`, enforces a watchdog, and returns the result with its destination register over a valid/ready writeback port.
- Exports stall and a busy-destination scoreboard so stage 1 can interlock.

Parameters:
- TIMEOUT, 15: RUN cycles allowed before a watchdog error completion.
- CNT_W, 4: width of the RUN-cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents an FPU operation.
- req_ready  out  1  scheduler accepts the request this cycle.
- req_opcode  in  5  instruction Opcode field [15:11].
- req_op1  in  16  Dest-register operand.
- req_op2  in  16  Op2 operand (register, PRE-extended or immediate).
- req_dest  in  4  destination register index.
- flush  in  1  abort the in-flight operation (taken jump).
- fpu_en  out  1  FPU enable.
- fpu_instr  out  6  to FPU `instr`, equal to {1'b0, latched opcode}.
- fpu_op1  out  16  latched op1.
- fpu_op2  out  16  latched op2.
- fpu_result  in  16  FPU result.
- fpu_done  in  1  FPU completion.
- wb_valid  out  1  writeback data available.
- wb_ready  in  1  stage 0 consumes the writeback.
- wb_dest  out  4  writeback register index.
- wb_data  out  16  writeback value.
- wb_err  out  1  error completion (unsupported opcode or timeout).
- busy  out  1  state != IDLE.
- busy_dest  out  4  dest of the in-flight op; 0 when idle.
- stall  out  1  hold upstream pipeline.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, all outputs 0 except req_ready=1. Reset mid-operation abandons the op silently.
- States: IDLE, RUN, WB.
- IDLE:
  - req_ready = !flush.
  - On req_valid && req_ready: latch opcode, op1, op2 and dest.
  - FPU opcode (itof 10010, ftoi 10011, recf 10100, mulf 10101, subf 10110, addf 10111): go to RUN next cycle.
  - Any other opcode: go to WB with wb_err=1 and wb_data=0. Latency 1.
- RUN:
  - fpu_en=1 and fpu_instr/op1/op2 held stable. Counter is cleared on entry and increments every RUN cycle.
  - fpu_done is ignored in the first RUN cycle (stale done from the previous op).
  - From the second RUN cycle on, fpu_done=1 captures fpu_result into wb_data, sets wb_err=0, and goes to WB. fpu_en is 0 from the next cycle.
  - If the counter reaches TIMEOUT with no qualified done: go to WB with wb_err=1 and wb_data=0.
- WB:
  - wb_valid=1 with wb_data/wb_dest/wb_err held until wb_ready=1.
  - On the handshake cycle: go to IDLE; wb_valid=0 next cycle.
  - Always at least 1 cycle, so the FPU sees at least one fpu_en=0 cycle between ops.
- stall = (state != IDLE) || (req_valid && !req_ready).
- busy_dest = latched dest when state != IDLE, else 0.
- flush:
  - In RUN or WB: go to IDLE next cycle, fpu_en=0 and wb_valid=0 next cycle, no writeback.
  - In IDLE: blocks acceptance.
  - flush with a qualified done in the same cycle: flush wins.
- No request queuing. Back-to-back ops are spaced at least 1 IDLE cycle apart.
- wb_dest=15 is legal; the scheduler passes it through and PC handling stays in stage 0.

Decomposition:
- Shared package `pinky_pkg`:
  - WORD and REG widths.
  - Opcode constants OPitof..OPaddf.
  - State encoding SCH_IDLE/SCH_RUN/SCH_WB.
  - FPU instr width (6).
- Sub-module `fpu_op_decode` (combinational): opcode -> {is_fpu, fpu_instr}. Reused by the stage-1 interlock logic.

Test Plan:
- itof 5 (op2=0x0005, dest=3), FPU model done after 3 cycles, wb_ready=1 -> wb_valid with wb_dest=3, wb_data=0x40A0, wb_err=0; fpu_en high exactly 3 cycles; stall high from acceptance until the WB handshake.
- itof op2=0xFFFF (-1) -> wb_data=0xBF80. itof op2=0x0000, with fpu_done held high from the previous op -> stale done ignored in the first RUN cycle, wb_data=0x0000.
- req_opcode=00000 (add) -> wb_valid 1 cycle after acceptance, wb_err=1, wb_data=0, fpu_en never asserted.
- FPU model never asserts done, TIMEOUT=15 -> wb_err=1 after 15 RUN cycles, fpu_en deasserted on the following cycle.
- flush in RUN coincident with fpu_done -> no wb_valid, IDLE next cycle, busy_dest=0; a following request is accepted normally.
- wb_ready held low 4 cycles, then reset pulsed low mid-WB -> wb_data stable and wb_valid high while waiting; asynchronous return to reset values with req_ready=1.
